// File: rtl/operand_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : operand_issue_ctrl
// Purpose  : Shares a 3-slot operand accumulator between NUM_REQ byte-stream
//            requesters. A round-robin winner streams 1..3 bytes into the
//            accumulator (PUT). Put then drops for one cycle so the
//            accumulator publishes r0..r2 (FLUSH). A command-valid handshake
//            is then held towards the execute stage until it is acknowledged
//            (ISSUE).
// Revision : 1.0 - initial release
//
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, ISSUE gives up after TIMEOUT_CYC cycles without cmd_ack_i.
//   In that case cmd_valid is dropped, cmd_err pulses and the FSM returns to
//   IDLE. When undefined, ISSUE waits for cmd_ack_i indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        per-requester command request (held until last byte taken)
//   req_len_i    per-requester byte count, 2 bits each (1..3, 0 = invalid)
//   req_data_i   per-requester current byte, DATA_W bits each
//   req_ready_o  per-requester byte accepted this cycle
//   acc_put_o    accumulator putFlag
//   acc_value_o  accumulator value
//   cmd_valid_o  r0..r2 hold a complete command
//   cmd_src_o    requester index owning the command
//   cmd_len_o    number of valid operand bytes
//   cmd_ack_i    execute stage consumed the command
//   cmd_err_o    one-cycle pulse: invalid length, abort or timeout
//   busy_o       controller not in IDLE
// ============================================================================
module operand_issue_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [2*NUM_REQ-1:0]      req_len_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      acc_put_o,
  output logic [DATA_W-1:0]         acc_value_o,
  output logic                      cmd_valid_o,
  output logic [1:0]                cmd_src_o,
  output logic [1:0]                cmd_len_o,
  input  logic                      cmd_ack_i,
  output logic                      cmd_err_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PUT   = 2'd1,
    S_FLUSH = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q,    rr_d;
  logic [1:0] len_q,   len_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       abort_q, abort_d;
  // rej_q marks the single IDLE cycle that reports a zero-length request.
  logic       rej_q,   rej_d;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_q,     to_d;
`endif

  logic       w_hit;
  logic [1:0] w_win;
  logic [1:0] w_win_len;
  logic       w_req_grant;

  function automatic logic [1:0] f_next_rr(input logic [1:0] g);
    f_next_rr = (g == 2'(NUM_REQ - 1)) ? 2'd0 : g + 2'd1;
  endfunction

  // Round-robin scan. The first loop finds the lowest asserted index overall
  // (the wrap-around candidate). The second loop overrides it with the lowest
  // asserted index at or above rr_q, when one exists.
  always_comb begin
    w_hit = 1'b0;
    w_win = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_hit = 1'b1;
        w_win = 2'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k] && (2'(k) >= rr_q)) begin
        w_win = 2'(k);
      end
    end
  end

  always_comb begin
    w_win_len   = 2'd0;
    w_req_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == 2'(k)) begin
        w_win_len = req_len_i[2*k +: 2];
      end
      if (grant_q == 2'(k)) begin
        w_req_grant = req_i[k];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    rej_d   = 1'b0;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d = '0;
    to_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // No scan during the reject cycle. The rejected requester is still
        // holding req while it sees its ready pulse and must not be
        // rejected twice.
        if (!rej_q && w_hit) begin
          grant_d = w_win;
          len_d   = w_win_len;
          cnt_d   = 2'd0;
          abort_d = 1'b0;
          if (w_win_len == 2'd0) begin
            rej_d = 1'b1;
            rr_d  = f_next_rr(w_win);
          end else begin
            state_d = S_PUT;
          end
        end
      end
      S_PUT: begin
        cnt_d = cnt_q + 2'd1;
        if (!w_req_grant) begin
          // The byte on the bus this cycle is still consumed. Flush and
          // discard the command.
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (cnt_q == len_q - 2'd1) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (abort_q) begin
          state_d = S_IDLE;
          rr_d    = f_next_rr(grant_q);
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ack_i) begin
          state_d = S_IDLE;
          rr_d    = f_next_rr(grant_q);
`ifdef CMD_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          rr_d    = f_next_rr(grant_q);
          to_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'd0;
      len_q   <= 2'd0;
      cnt_q   <= 2'd0;
      abort_q <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      rej_q   <= rej_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end
`endif

  // Moore output decode
  always_comb begin
    acc_put_o   = (state_q == S_PUT);
    cmd_valid_o = (state_q == S_ISSUE);
    cmd_src_o   = (state_q == S_ISSUE) ? grant_q : 2'd0;
    cmd_len_o   = (state_q == S_ISSUE) ? len_q   : 2'd0;
    busy_o      = (state_q != S_IDLE);
    cmd_err_o   = rej_q | ((state_q == S_FLUSH) && abort_q);
`ifdef CMD_TIMEOUT_EN
    cmd_err_o   = cmd_err_o | to_q;
`endif
    acc_value_o = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == 2'(k)) begin
        req_ready_o[k] = (state_q == S_PUT) | rej_q;
        if (state_q == S_PUT) begin
          acc_value_o = req_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
module tb_operand_issue_ctrl;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int TOC     = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_i;
  logic [2*NUM_REQ-1:0]      req_len_i;
  logic [DATA_W*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      acc_put_o;
  logic [DATA_W-1:0]         acc_value_o;
  logic                      cmd_valid_o;
  logic [1:0]                cmd_src_o;
  logic [1:0]                cmd_len_o;
  logic                      cmd_ack_i;
  logic                      cmd_err_o;
  logic                      busy_o;

  always #5 clk = ~clk;

  operand_issue_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .req_len_i(req_len_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .acc_put_o(acc_put_o), .acc_value_o(acc_value_o),
    .cmd_valid_o(cmd_valid_o), .cmd_src_o(cmd_src_o), .cmd_len_o(cmd_len_o),
    .cmd_ack_i(cmd_ack_i), .cmd_err_o(cmd_err_o), .busy_o(busy_o)
  );

  typedef struct {
    bit         is_err;
    logic [1:0] src;
    logic [1:0] len;
    logic [7:0] b0, b1, b2;
  } exp_t;

  typedef struct {
    logic [1:0] len;
    logic [7:0] b0, b1, b2;
    int         abort_n;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t pend0[$];
  cmd_t pend1[$];
  int   v_rise[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_cmd(input logic [1:0] src, input logic [1:0] len,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    e.is_err = 1'b0; e.src = src; e.len = len; e.b0 = b0; e.b1 = b1; e.b2 = b2;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.src = 2'd0; e.len = 2'd0; e.b0 = 8'h0; e.b1 = 8'h0; e.b2 = 8'h0;
    exp_q.push_back(e);
  endtask

  task automatic add_cmd(input int r, input logic [1:0] len, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input int abort_n);
    cmd_t c;
    c.len = len; c.b0 = b0; c.b1 = b1; c.b2 = b2; c.abort_n = abort_n;
    if (r == 0) pend0.push_back(c);
    else        pend1.push_back(c);
  endtask

  // ---------------- accumulator model (external block) ----------------
  logic [7:0] s0 = 8'h0, s1 = 8'h0, s2 = 8'h0;
  logic [7:0] r0 = 8'h0, r1 = 8'h0, r2 = 8'h0;
  int         acnt = 0;
  always @(posedge clk) begin
    if (acc_put_o) begin
      if (acnt == 0) s0 <= acc_value_o;
      if (acnt == 1) s1 <= acc_value_o;
      if (acnt == 2) s2 <= acc_value_o;
      acnt <= acnt + 1;
    end else if (acnt > 0) begin
      r0 <= s0; r1 <= s1; r2 <= s2;
      acnt <= 0;
    end
  end

  // ---------------- requester models ----------------
  logic       act[2];
  logic [1:0] cur_len[2];
  logic [7:0] cur_b[2][3];
  int         cur_idx[2];
  int         cur_abort[2];
  int         t_load[2];
  logic [1:0] rdy_s = 2'b00;

  function automatic int clamp2(input int v);
    clamp2 = (v > 2) ? 2 : v;
  endfunction

  task automatic update_pins();
    req_i      = {act[1], act[0]};
    req_len_i  = {cur_len[1], cur_len[0]};
    req_data_i = {cur_b[1][clamp2(cur_idx[1])], cur_b[0][clamp2(cur_idx[0])]};
  endtask

  task automatic load_next(input int r);
    cmd_t c;
    bit   got;
    got = 1'b0;
    if (r == 0 && pend0.size() > 0) begin c = pend0.pop_front(); got = 1'b1; end
    if (r == 1 && pend1.size() > 0) begin c = pend1.pop_front(); got = 1'b1; end
    if (got) begin
      act[r] = 1'b1; cur_len[r] = c.len; cur_idx[r] = 0; cur_abort[r] = c.abort_n;
      cur_b[r][0] = c.b0; cur_b[r][1] = c.b1; cur_b[r][2] = c.b2;
      t_load[r] = cyc;
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      act[r] = 1'b0; cur_len[r] = 2'd0; cur_idx[r] = 0; cur_abort[r] = 0; t_load[r] = 0;
      for (int b = 0; b < 3; b++) cur_b[r][b] = 8'h00;
    end
    update_pins();
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        bit fin;
        fin = 1'b0;
        if (!rst_n) begin
          act[r] = 1'b0; fin = 1'b1;
        end else if (act[r] && rdy_s[r]) begin
          cur_idx[r]++;
          if (cur_len[r] == 2'd0 || cur_idx[r] == int'(cur_len[r]) || cur_idx[r] == cur_abort[r]) begin
            act[r] = 1'b0; fin = 1'b1;
          end
        end
        if (!act[r] && !fin) load_next(r);
      end
      update_pins();
    end
  end

  // ---------------- execute-stage ack model ----------------
  int ack_wait = 0;   // -1: never acknowledge
  int vcnt = 0;
  initial begin
    cmd_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cmd_valid_o) begin
        cmd_ack_i = (ack_wait >= 0) && (vcnt >= ack_wait);
        vcnt++;
      end else begin
        cmd_ack_i = 1'b0;
        vcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic p_put = 1'b0, p_val = 1'b0, p_busy = 1'b0;
  int   put_cnt = 0, put_rise = -1, v_fall = -1, idle_at = -1, err_cyc = -1;

  task automatic sb_cmd();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_cmd", 32'(cmd_src_o), 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind_cmd", 32'(e.is_err), 0);
      chk("cmd_src", 32'(cmd_src_o), 32'(e.src));
      chk("cmd_len", 32'(cmd_len_o), 32'(e.len));
      chk("r0", 32'(r0), 32'(e.b0));
      if (e.len >= 2) chk("r1", 32'(r1), 32'(e.b1));
      if (e.len == 3) chk("r2", 32'(r2), 32'(e.b2));
    end
  endtask

  task automatic sb_err();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_err", 32'(cmd_err_o), 0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind_err", 32'(e.is_err), 1);
    end
  endtask

  always @(negedge clk) begin
    rdy_s = req_ready_o;
    if (rst_n) begin
      if (acc_put_o) put_cnt++;
      if (acc_put_o && !p_put) put_rise = cyc;
      if (cmd_valid_o && !p_val) begin v_rise.push_back(cyc); sb_cmd(); end
      if (!cmd_valid_o && p_val) v_fall = cyc;
      if (!busy_o && p_busy) idle_at = cyc;
      if (cmd_err_o) begin err_cyc = cyc; sb_err(); end
    end
    p_put  = acc_put_o;
    p_val  = cmd_valid_o;
    p_busy = busy_o;
  end

  task automatic wait_quiet(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(req_i == 2'b00 && !busy_o && pend0.size() == 0 && pend1.size() == 0 &&
                 exp_q.size() == 0) && n < budget);
    chk(name, 32'(n < budget), 1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!cmd_valid_o && n < budget) begin @(negedge clk); n++; end
    chk(name, 32'(cmd_valid_o), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t, pc, nv, n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc_put",   32'(acc_put_o),   0);
    chk("rst_acc_value", 32'(acc_value_o), 0);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_cmd_src",   32'(cmd_src_o),   0);
    chk("rst_cmd_len",   32'(cmd_len_o),   0);
    chk("rst_cmd_err",   32'(cmd_err_o),   0);
    chk("rst_busy",      32'(busy_o),      0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single requester, len 3, ack on third ISSUE cycle
    ack_wait = 2;
    pc = put_cnt;
    exp_cmd(2'd0, 2'd3, 8'h11, 8'h22, 8'h33);
    add_cmd(0, 2'd3, 8'h11, 8'h22, 8'h33, 0);
    wait_quiet(60, "t1_done");
    t = t_load[0];
    chk("t1_put_rise",  32'(put_rise),     32'(t + 1));
    chk("t1_valid_at",  32'(v_rise[$]),    32'(t + 5));
    chk("t1_idle_at",   32'(idle_at),      32'(t + 8));
    chk("t1_put_count", 32'(put_cnt - pc), 3);

    // 2: both requesters, len 1, immediate ack; rr points at 1 after test 1
    ack_wait = 0;
    pc = put_cnt;
    nv = v_rise.size();
    exp_cmd(2'd1, 2'd1, 8'hB1, 8'h0, 8'h0);
    exp_cmd(2'd0, 2'd1, 8'hA1, 8'h0, 8'h0);
    exp_cmd(2'd1, 2'd1, 8'hB3, 8'h0, 8'h0);
    exp_cmd(2'd0, 2'd1, 8'hA3, 8'h0, 8'h0);
    add_cmd(0, 2'd1, 8'hA1, 8'h0, 8'h0, 0);
    add_cmd(0, 2'd1, 8'hA3, 8'h0, 8'h0, 0);
    add_cmd(1, 2'd1, 8'hB1, 8'h0, 8'h0, 0);
    add_cmd(1, 2'd1, 8'hB3, 8'h0, 8'h0, 0);
    wait_quiet(100, "t2_done");
    chk("t2_num_cmds", 32'(v_rise.size() - nv), 4);
    if (v_rise.size() - nv == 4) begin
      for (int i = nv + 1; i < nv + 4; i++) chk("t2_period", 32'(v_rise[i] - v_rise[i-1]), 4);
    end
    chk("t2_put_count", 32'(put_cnt - pc), 4);

    // 3: requester 1 with len 0 wins (rr=1), rejected, then requester 0
    pc = put_cnt;
    exp_err();
    exp_cmd(2'd0, 2'd1, 8'hC1, 8'h0, 8'h0);
    add_cmd(1, 2'd0, 8'hEE, 8'h0, 8'h0, 0);
    add_cmd(0, 2'd1, 8'hC1, 8'h0, 8'h0, 0);
    wait_quiet(60, "t3_done");
    chk("t3_err_at",    32'(err_cyc),      32'(t_load[1] + 1));
    chk("t3_put_count", 32'(put_cnt - pc), 1);

    // 4: abort after the first byte, then a fresh len 2 command
    pc = put_cnt;
    nv = v_rise.size();
    exp_err();
    exp_cmd(2'd0, 2'd2, 8'h44, 8'h55, 8'h0);
    add_cmd(0, 2'd3, 8'h11, 8'h22, 8'h33, 1);
    add_cmd(0, 2'd2, 8'h44, 8'h55, 8'h00, 0);
    n = 0;
    while (!act[0] && n < 10) begin @(negedge clk); n++; end
    t = t_load[0];
    wait_quiet(60, "t4_done");
    chk("t4_err_at",    32'(err_cyc),              32'(t + 3));
    chk("t4_num_cmds",  32'(v_rise.size() - nv),   1);
    chk("t4_put_count", 32'(put_cnt - pc),         4);

    // 5: reset during PUT count=1
    add_cmd(0, 2'd3, 8'h77, 8'h88, 8'h99, 0);
    n = 0;
    while (!acc_put_o && n < 20) begin @(negedge clk); n++; end
    chk("t5_put_seen", 32'(acc_put_o), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_put",   32'(acc_put_o),   0);
    chk("t5_rst_value", 32'(acc_value_o), 0);
    chk("t5_rst_ready", 32'(req_ready_o), 0);
    chk("t5_rst_busy",  32'(busy_o),      0);
    chk("t5_rst_valid", 32'(cmd_valid_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cmd(2'd0, 2'd2, 8'hA5, 8'h5A, 8'h0);
    add_cmd(0, 2'd2, 8'hA5, 8'h5A, 8'h00, 0);
    wait_quiet(60, "t5_done");

    // 6: no acknowledge
    ack_wait = -1;
    exp_cmd(2'd0, 2'd1, 8'hE7, 8'h0, 8'h0);
`ifdef CMD_TIMEOUT_EN
    exp_err();
`endif
    add_cmd(0, 2'd1, 8'hE7, 8'h0, 8'h0, 0);
    wait_valid(30, "t6_valid_seen");
    t = v_rise[$];
`ifdef CMD_TIMEOUT_EN
    repeat (TOC + 4) @(negedge clk);
    chk("t6_valid_fall_at", 32'(v_fall),  32'(t + TOC));
    chk("t6_err_at",        32'(err_cyc), 32'(t + TOC));
    chk("t6_valid_low",     32'(cmd_valid_o), 0);
    ack_wait = 0;
`else
    repeat (100) @(negedge clk);
    chk("t6_valid_held", 32'(cmd_valid_o), 1);
    chk("t6_src_held",   32'(cmd_src_o),   0);
    chk("t6_len_held",   32'(cmd_len_o),   1);
    ack_wait = 0;
`endif
    wait_quiet(40, "t6_done");

    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
